// File: rtl/sr04_multi.sv
// -----------------------------------------------------------------------------
// sr04_multi -- multi-channel HC-SR04 ultrasonic ranging controller
//
// Fires CHANNELS sensors in round-robin order. For each channel it drives a
// trigger pulse, waits for the echo to rise, times the echo width in
// microseconds, waits a quiet holdoff and then moves to the next channel.
// Every measurement produces one result record: channel, value and a timeout
// flag.
//
// Optional feature macro: SR04_CM_EN
//   When this macro is defined, result_value is reported in centimetres
//   (floor(us / CM_DIV_US)). When it is undefined, result_value is reported in
//   microseconds and the centimetre logic is not built.
//
// Ports
//   clk                 in   system clock
//   reset               in   asynchronous active-high reset
//   en                  in   1 = run continuous round-robin ranging
//   sensor_trigger_out  out  [CHANNELS] per-sensor trigger, active high
//   sensor_echo_in      in   [CHANNELS] per-sensor echo, asynchronous
//   result_valid        out  one-cycle strobe, result fields valid
//   result_chan         out  [CH_W] channel of this result
//   result_value        out  [WIDTH] echo width (us, or cm with SR04_CM_EN)
//   result_timeout      out  1 = no echo rise, or echo too long
//   busy                out  1 = controller not idle
// -----------------------------------------------------------------------------
module sr04_multi #(
  parameter int CHANNELS        = 4,
  parameter int CLK_FREQ_HZ     = 16000000,
  parameter int TRIG_US         = 10,
  parameter int ECHO_TIMEOUT_US = 30000,
  parameter int HOLDOFF_US      = 60000,
  parameter int WIDTH           = 16,
  parameter int CM_DIV_US       = 58,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [CHANNELS-1:0] sensor_trigger_out,
  input  logic [CHANNELS-1:0] sensor_echo_in,
  output logic                result_valid,
  output logic [CH_W-1:0]     result_chan,
  output logic [WIDTH-1:0]    result_value,
  output logic                result_timeout,
  output logic                busy
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int US_DIV_RAW = CLK_FREQ_HZ / 1000000;
  localparam int US_DIV     = (US_DIV_RAW < 1) ? 1 : US_DIV_RAW;
  localparam int PW         = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  localparam int CNT_MAX_A  = (TRIG_US > ECHO_TIMEOUT_US) ? TRIG_US : ECHO_TIMEOUT_US;
  localparam int CNT_MAX    = (CNT_MAX_A > HOLDOFF_US) ? CNT_MAX_A : HOLDOFF_US;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(US_DIV - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST  = CNT_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_US - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [CH_W-1:0]  PTR_LAST   = CH_W'(CHANNELS - 1);

  // The echo edge is seen one cycle before MEASURE is entered. That cycle is
  // already part of the echo, so the first microsecond of MEASURE is started
  // one cycle early. With a 1-cycle microsecond the detection cycle is itself
  // a full microsecond, so the count starts at one instead.
  localparam logic [PW-1:0]    PRESC_MEAS_START = PW'((US_DIV > 1) ? 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MEAS_START   = CNT_W'((US_DIV > 1) ? 0 : 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic                echo_prev_q;
  logic                result_valid_q, result_valid_d;
  logic [CH_W-1:0]     result_chan_q, result_chan_d;
  logic [WIDTH-1:0]    result_value_q, result_value_d;
  logic                result_timeout_q, result_timeout_d;

  logic [CHANNELS-1:0] echo_sync;
  logic                echo_sel;
  logic                tick;
  logic                entering;
  logic                trig_active;
  logic                rep_valid;
  logic                rep_timeout;
  logic [WIDTH-1:0]    rep_value;
  logic [WIDTH-1:0]    meas_value;

  // ---------------------------------------------------------------------------
  // Echo synchronisers, one 2-flop chain per channel
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_echo_sync
      logic meta_q;
      logic sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= sensor_echo_in[gi];
          sync_q <= meta_q;
        end
      end
      assign echo_sync[gi] = sync_q;
    end
  endgenerate

  assign echo_sel = echo_sync[ptr_q];
  assign tick     = (presc_q == PRESC_LAST);
  assign entering = (state_d != state_q);

  // ---------------------------------------------------------------------------
  // Centimetre conversion (optional)
  // ---------------------------------------------------------------------------
`ifdef SR04_CM_EN
  localparam int CMW = (CM_DIV_US > 1) ? $clog2(CM_DIV_US) : 1;
  localparam logic [CMW-1:0]   CM_LAST           = CMW'(CM_DIV_US - 1);
  localparam logic [CMW-1:0]   CM_PRESC_START    = CMW'((US_DIV > 1 || CM_DIV_US == 1) ? 0 : 1);
  localparam logic [WIDTH-1:0] CM_CNT_START      = WIDTH'((US_DIV == 1 && CM_DIV_US == 1) ? 1 : 0);
  localparam logic [WIDTH-1:0] TIMEOUT_VALUE     = WIDTH'(ECHO_TIMEOUT_US / CM_DIV_US);

  logic [CMW-1:0]   cm_presc_q, cm_presc_d;
  logic [WIDTH-1:0] cm_cnt_q, cm_cnt_d;

  // Second prescaler: divides microsecond ticks down to centimetres.
  always_comb begin
    cm_presc_d = cm_presc_q;
    cm_cnt_d   = cm_cnt_q;
    if (entering && state_d == S_MEASURE) begin
      cm_presc_d = CM_PRESC_START;
      cm_cnt_d   = CM_CNT_START;
    end else if (state_q == S_MEASURE && tick) begin
      if (cm_presc_q == CM_LAST) begin
        cm_presc_d = '0;
        if (cm_cnt_q != '1) cm_cnt_d = cm_cnt_q + 1'b1;
      end else begin
        cm_presc_d = cm_presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cm_presc_q <= '0;
      cm_cnt_q   <= '0;
    end else begin
      cm_presc_q <= cm_presc_d;
      cm_cnt_q   <= cm_cnt_d;
    end
  end

  assign meas_value = cm_cnt_q;
`else
  localparam logic [WIDTH-1:0] TIMEOUT_VALUE = WIDTH'(ECHO_TIMEOUT_US);
  assign meas_value = WIDTH'(cnt_q);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and result reporting
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rep_valid   = 1'b0;
    rep_timeout = 1'b0;
    rep_value   = '0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (tick && cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // Only a genuine low-to-high transition counts; a level that was
        // already high when this state was entered is ignored.
        if (echo_sel && !echo_prev_q) begin
          state_d = S_MEASURE;
        end else if (tick && cnt_q == ECHO_LAST) begin
          state_d     = S_HOLDOFF;
          rep_valid   = 1'b1;
          rep_timeout = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!echo_sel) begin
          state_d   = S_HOLDOFF;
          rep_valid = 1'b1;
          rep_value = meas_value;
        end else if (tick && cnt_q == ECHO_LAST) begin
          state_d     = S_HOLDOFF;
          rep_valid   = 1'b1;
          rep_timeout = 1'b1;
          rep_value   = TIMEOUT_VALUE;
        end
      end
      S_HOLDOFF: begin
        if (tick && cnt_q == HOLD_LAST) state_d = en ? S_TRIG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    trig_active = (state_q == S_TRIG);
    busy        = (state_q != S_IDLE);
  end

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_trig
      assign sensor_trigger_out[gi] = trig_active && (ptr_q == CH_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Datapath: prescaler, tick counter, channel pointer, result registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // Prescaler and tick counter restart whenever a new state is entered.
    if (entering) begin
      presc_d = (state_d == S_MEASURE) ? PRESC_MEAS_START : '0;
      cnt_d   = (state_d == S_MEASURE) ? CNT_MEAS_START : '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = (tick && cnt_q != CNT_SAT) ? cnt_q + 1'b1 : cnt_q;
    end

    ptr_d = ptr_q;
    if (state_q == S_HOLDOFF && entering) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    result_valid_d   = rep_valid;
    result_chan_d    = result_chan_q;
    result_value_d   = result_value_q;
    result_timeout_d = result_timeout_q;
    if (rep_valid) begin
      result_chan_d    = ptr_q;
      result_value_d   = rep_value;
      result_timeout_d = rep_timeout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q          <= '0;
      cnt_q            <= '0;
      ptr_q            <= '0;
      echo_prev_q      <= 1'b0;
      result_valid_q   <= 1'b0;
      result_chan_q    <= '0;
      result_value_q   <= '0;
      result_timeout_q <= 1'b0;
    end else begin
      presc_q          <= presc_d;
      cnt_q            <= cnt_d;
      ptr_q            <= ptr_d;
      echo_prev_q      <= echo_sel;
      result_valid_q   <= result_valid_d;
      result_chan_q    <= result_chan_d;
      result_value_q   <= result_value_d;
      result_timeout_q <= result_timeout_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_chan    = result_chan_q;
  assign result_value   = result_value_q;
  assign result_timeout = result_timeout_q;

endmodule

// File: tb/tb_sr04_multi.sv
// -----------------------------------------------------------------------------
// tb_sr04_multi -- directed self-checking bench for sr04_multi
//
// 2 MHz clock (2 cycles per us), 4 channels, 10 us trigger, 1000 us echo
// timeout, 200 us holdoff. Echo stimulus is applied on falling clock edges and
// all outputs are sampled on falling edges. Build with +define+SR04_CM_EN to
// check centimetre results (floor(us / 58)).
// -----------------------------------------------------------------------------
module tb_sr04_multi;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [3:0]  echo  = 4'b0000;
  logic [3:0]  trig;
  logic        result_valid;
  logic [1:0]  result_chan;
  logic [15:0] result_value;
  logic        result_timeout;
  logic        busy;

  int n_checks   = 0;
  int n_errors   = 0;
  int strobe_cnt = 0;

  sr04_multi #(
    .CHANNELS        (4),
    .CLK_FREQ_HZ     (2000000),
    .TRIG_US         (10),
    .ECHO_TIMEOUT_US (1000),
    .HOLDOFF_US      (200),
    .WIDTH           (16),
    .CM_DIV_US       (58)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .en                 (en),
    .sensor_trigger_out (trig),
    .sensor_echo_in     (echo),
    .result_valid       (result_valid),
    .result_chan        (result_chan),
    .result_value       (result_value),
    .result_timeout     (result_timeout),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) strobe_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before 600000 ns");
    $fatal(1, "watchdog expired");
  end

  function automatic int scale(input int us);
`ifdef SR04_CM_EN
    return us / 58;
`else
    return us;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for a trigger pulse, checks channel and width; returns at the first
  // falling edge after the trigger has dropped (first WAIT_RISE cycle).
  task automatic trig_pulse(input int ch, output int gap);
    int n;
    int w;
    logic [3:0] exp_sel;
    n = 0;
    while (trig == 4'b0000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    exp_sel = 4'b0001 << ch;
    check($sformatf("trig%0d_sel", ch), 32'(trig), 32'(exp_sel));
    check($sformatf("trig%0d_busy", ch), 32'(busy), 32'd1);
    w = 0;
    while (trig != 4'b0000 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("trig%0d_width", ch), 32'(w), 32'd20);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!result_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(result_valid), 32'd1);
  endtask

  task automatic check_result(input int ch, input int exp_us, input int exp_to, input int lat, input int exp_lat);
    check($sformatf("ch%0d_latency", ch), 32'(lat), 32'(exp_lat));
    check($sformatf("ch%0d_chan", ch), 32'(result_chan), 32'(ch));
    check($sformatf("ch%0d_value", ch), 32'(result_value), 32'(scale(exp_us)));
    check($sformatf("ch%0d_timeout", ch), 32'(result_timeout), 32'(exp_to));
    $display("result ch=%0d value=%0d timeout=%0d latency=%0d", result_chan, result_value, result_timeout, lat);
    @(negedge clk);
    check($sformatf("ch%0d_strobe_1cyc", ch), 32'(result_valid), 32'd0);
    check($sformatf("ch%0d_value_hold", ch), 32'(result_value), 32'(scale(exp_us)));
  endtask

  task automatic run_echo(input int ch, input int delay, input int width, input int exp_us,
                          input int exp_to, input int exp_gap, input int exp_lat);
    int gap;
    int lat;
    trig_pulse(ch, gap);
    check($sformatf("ch%0d_gap", ch), 32'(gap), 32'(exp_gap));
    repeat (delay) @(negedge clk);
    if (width > 0) begin
      echo[ch] = 1'b1;
      repeat (width) @(negedge clk);
      echo[ch] = 1'b0;
    end
    wait_strobe(lat);
    check_result(ch, exp_us, exp_to, lat, exp_lat);
  endtask

  initial begin
    int gap;
    int lat;
    int n;
    int trig_hi;
    int strobes_before;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chan", 32'(result_chan), 32'd0);
    check("rst_value", 32'(result_value), 32'd0);
    check("rst_timeout", 32'(result_timeout), 32'd0);

    reset = 1'b0;
    en    = 1'b1;

    // ch0: 580 us echo starting ~100 us after the trigger
    run_echo(0, 199, 1160, 580, 0, 1, 3);
    // ch1: echo never rises -> timeout after exactly 1000 us
    run_echo(1, 0, 0, 0, 1, 399, 2000);

    // ch2: echo stuck high -> measurement capped at 1000 us
    trig_pulse(2, gap);
    check("ch2_gap", 32'(gap), 32'd399);
    echo[2] = 1'b1;
    wait_strobe(lat);
    check_result(2, 1000, 1, lat, 2002);

    // ch3 with ch2's echo still high: only the selected channel matters
    run_echo(3, 50, 600, 300, 0, 399, 3);
    echo[2] = 1'b0;

    // wrap back to ch0, then a second round
    run_echo(0, 10, 100, 50, 0, 399, 3);
    run_echo(1, 10, 40, 20, 0, 399, 3);
    run_echo(2, 10, 60, 30, 0, 399, 3);

    // ch3: en dropped mid-measurement, result still reported, then idle
    trig_pulse(3, gap);
    check("ch3_en_gap", 32'(gap), 32'd399);
    echo[3] = 1'b1;
    repeat (100) @(negedge clk);
    en = 1'b0;
    repeat (300) @(negedge clk);
    echo[3] = 1'b0;
    wait_strobe(lat);
    check_result(3, 200, 0, lat, 3);
    check("holdoff_busy", 32'(busy), 32'd1);
    trig_hi = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (trig != 4'b0000) trig_hi++;
    end
    check("idle_no_trig", 32'(trig_hi), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("strobe_total", 32'(strobe_cnt), 32'd8);

    // restart from idle on ch0, then reset in the middle of ch1's trigger
    en = 1'b1;
    run_echo(0, 10, 20, 10, 0, 1, 3);
    n = 0;
    while (trig == 4'b0000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ch1_pre_rst_gap", 32'(n), 32'd399);
    check("ch1_pre_rst_sel", 32'(trig), 32'd2);
    repeat (5) @(negedge clk);
    strobes_before = strobe_cnt;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_trig", 32'(trig), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_valid", 32'(result_valid), 32'd0);
    check("rst_mid_value", 32'(result_value), 32'd0);
    reset = 1'b0;
    run_echo(0, 10, 20, 10, 0, 1, 3);
    check("rst_no_strobe", 32'(strobe_cnt), 32'(strobes_before + 1));
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
